// File: rtl/falafel_pkg.sv
// Shared falafel types and constants: word width, word type and byte-to-word address shift.
package falafel_pkg;

    localparam int DATA_W       = 32;
    localparam int WORD_SIZE    = DATA_W / 8;
    localparam int MEM_ADDR_LSB = $clog2(WORD_SIZE);

    typedef logic [DATA_W-1:0] word_t;

endpackage : falafel_pkg

// File: rtl/falafel_mem_responder_chk.sv
// Protocol checks for the responder's response queue and credit counter.
module falafel_mem_responder_chk #(
    parameter int RSP_DEPTH = 4,
    parameter int CNT_W     = 3
) (
    input logic             clk_i,
    input logic             rst_i,
    input logic             push,
    input logic             full,
    input logic             pop,
    input logic             empty,
    input logic [CNT_W-1:0] inflight
);

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(pop && empty));
    a_inflight_max: assert property (@(posedge clk_i) disable iff (rst_i) inflight <= CNT_W'(RSP_DEPTH));

endmodule : falafel_mem_responder_chk

// File: rtl/falafel_rsp_fifo.sv
// First-word fall-through response queue; head entry is visible on pop_data whenever !empty.
module falafel_rsp_fifo
    import falafel_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  push,
    input  word_t push_data,
    input  logic  pop,
    output word_t pop_data,
    output logic  full,
    output logic  empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    word_t              fifo_mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               do_push_s;
    logic               do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign pop_data  = fifo_mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            fifo_mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule : falafel_rsp_fifo

// File: rtl/falafel_mem_responder.sv
// Word-wide SRAM model behind falafel_core's mem_req/mem_rsp port: access at accept,
// fixed-latency delay line, in-order response queue, credit-based request ready.
module falafel_mem_responder
    import falafel_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  mem_req_val_i,
    output logic  mem_req_rdy_o,
    input  logic  mem_req_is_write_i,
    input  word_t mem_req_addr_i,
    input  word_t mem_req_data_i,
    output logic  mem_rsp_val_o,
    input  logic  mem_rsp_rdy_i,
    output word_t mem_rsp_data_o,
    input  logic  dbg_we_i,
    input  word_t dbg_addr_i,
    input  word_t dbg_data_i,
    output logic  err_o
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int PIPE_N = LATENCY - 1;

    // Full word address compared against DEPTH so aliasing high addresses count as out of range.
    function automatic logic addr_in_range(input word_t addr);
        return (addr >> MEM_ADDR_LSB) < word_t'(DEPTH);
    endfunction

    word_t              mem_r [DEPTH];
    logic               rdy_en_r;
    logic [CNT_W-1:0]   inflight_r;
    logic               err_r;

    logic               accept_s;
    logic               pop_s;
    logic [IDX_W-1:0]   req_idx_s;
    logic [IDX_W-1:0]   dbg_idx_s;
    logic               req_ok_s;
    logic               dbg_ok_s;
    word_t              rsp_word_s;
    logic               push_s;
    word_t              push_data_s;
    word_t              fifo_head_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;

    assign req_idx_s = mem_req_addr_i[MEM_ADDR_LSB +: IDX_W];
    assign dbg_idx_s = dbg_addr_i[MEM_ADDR_LSB +: IDX_W];
    assign req_ok_s  = addr_in_range(mem_req_addr_i);
    assign dbg_ok_s  = addr_in_range(dbg_addr_i);

    assign mem_req_rdy_o  = !rst_i && rdy_en_r && (inflight_r < CNT_W'(RSP_DEPTH)) && !dbg_we_i;
    assign accept_s       = mem_req_val_i && mem_req_rdy_o;
    assign mem_rsp_val_o  = !fifo_empty_s;
    assign mem_rsp_data_o = fifo_empty_s ? '0 : fifo_head_s;
    assign pop_s          = mem_rsp_val_o && mem_rsp_rdy_i;
    assign err_o          = err_r;

    // Response payload formed at accept: writes echo their data, out-of-range reads return zero.
    always_comb begin
        rsp_word_s = '0;
        if (mem_req_is_write_i) begin
            rsp_word_s = mem_req_data_i;
        end else if (req_ok_s) begin
            rsp_word_s = mem_r[req_idx_s];
        end else begin
            rsp_word_s = '0;
        end
    end

    // Heap array: backdoor wins the cycle; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (dbg_we_i) begin
            if (dbg_ok_s) begin
                mem_r[dbg_idx_s] <= dbg_data_i;
            end
        end else if (accept_s && mem_req_is_write_i && req_ok_s) begin
            mem_r[req_idx_s] <= mem_req_data_i;
        end
    end

    // Control state: ready enable, credit counter and sticky range error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdy_en_r   <= 1'b0;
            inflight_r <= {CNT_W{1'b0}};
            err_r      <= 1'b0;
        end else begin
            rdy_en_r <= 1'b1;
            case ({accept_s, pop_s})
                2'b10:   inflight_r <= inflight_r + CNT_W'(1);
                2'b01:   inflight_r <= inflight_r - CNT_W'(1);
                default: inflight_r <= inflight_r;
            endcase
            if ((accept_s && !req_ok_s) || (dbg_we_i && !dbg_ok_s)) begin
                err_r <= 1'b1;
            end
        end
    end

    // The queue's registered head provides the final latency cycle, so the line is LATENCY-1 deep.
    generate
        if (PIPE_N > 0) begin : g_pipe
            logic [PIPE_N-1:0] pipe_vld_r;
            word_t             pipe_data_r [PIPE_N];

            // Delay line shift; only the valid bits need flushing.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    pipe_vld_r <= {PIPE_N{1'b0}};
                end else begin
                    pipe_vld_r[0] <= accept_s;
                    for (int i = 1; i < PIPE_N; i++) begin
                        pipe_vld_r[i] <= pipe_vld_r[i-1];
                    end
                end
                pipe_data_r[0] <= rsp_word_s;
                for (int i = 1; i < PIPE_N; i++) begin
                    pipe_data_r[i] <= pipe_data_r[i-1];
                end
            end

            assign push_s      = pipe_vld_r[PIPE_N-1];
            assign push_data_s = pipe_data_r[PIPE_N-1];
        end else begin : g_nopipe
            assign push_s      = accept_s;
            assign push_data_s = rsp_word_s;
        end
    endgenerate

    falafel_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    falafel_mem_responder_chk #(
        .RSP_DEPTH (RSP_DEPTH),
        .CNT_W     (CNT_W)
    ) u_chk (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (push_s),
        .full     (fifo_full_s),
        .pop      (pop_s),
        .empty    (fifo_empty_s),
        .inflight (inflight_r)
    );

endmodule : falafel_mem_responder

// File: tb/tb_falafel_mem_responder.sv
// Scoreboard bench for falafel_mem_responder: directed requests push expected words,
// a negedge monitor pops and compares every accepted response.
module tb_falafel_mem_responder;
    import falafel_pkg::*;

    localparam int DEPTH = 1024;

    logic  clk = 1'b0;
    logic  rst_i;
    logic  mem_req_val_i;
    logic  mem_req_rdy_o;
    logic  mem_req_is_write_i;
    word_t mem_req_addr_i;
    word_t mem_req_data_i;
    logic  mem_rsp_val_o;
    logic  mem_rsp_rdy_i;
    word_t mem_rsp_data_o;
    logic  dbg_we_i;
    word_t dbg_addr_i;
    word_t dbg_data_i;
    logic  err_o;

    int    n_checks = 0;
    int    n_fail   = 0;
    word_t exp_q [$];

    falafel_mem_responder #(.DEPTH(DEPTH), .LATENCY(2), .RSP_DEPTH(4)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .mem_req_val_i      (mem_req_val_i),
        .mem_req_rdy_o      (mem_req_rdy_o),
        .mem_req_is_write_i (mem_req_is_write_i),
        .mem_req_addr_i     (mem_req_addr_i),
        .mem_req_data_i     (mem_req_data_i),
        .mem_rsp_val_o      (mem_rsp_val_o),
        .mem_rsp_rdy_i      (mem_rsp_rdy_i),
        .mem_rsp_data_o     (mem_rsp_data_o),
        .dbg_we_i           (dbg_we_i),
        .dbg_addr_i         (dbg_addr_i),
        .dbg_data_i         (dbg_data_i),
        .err_o              (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input word_t act, input word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every handshaken response must match the oldest expected word.
    always @(negedge clk) begin
        if (mem_rsp_val_o === 1'b1 && mem_rsp_rdy_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got %h expected none", mem_rsp_data_o);
            end else begin
                check("rsp_data", mem_rsp_data_o, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_write(input word_t addr, input word_t data);
        dbg_we_i = 1'b1; dbg_addr_i = addr; dbg_data_i = data;
        tick();
        dbg_we_i = 1'b0;
    endtask

    // Returns just after the accepting edge.
    task automatic req(input logic we, input word_t addr, input word_t data, input word_t exp);
        bit got = 1'b0;
        mem_req_val_i = 1'b1; mem_req_is_write_i = we;
        mem_req_addr_i = addr; mem_req_data_i = data;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_req_rdy_o) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
        end
        check("req_accept", word_t'(got), word_t'(1));
        if (got) exp_q.push_back(exp);
        tick();
        mem_req_val_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !mem_rsp_val_o) break;
            tick();
        end
        check("drain", word_t'(exp_q.size()), word_t'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_i = 1'b1; mem_req_val_i = 1'b0; mem_req_is_write_i = 1'b0;
        mem_req_addr_i = '0; mem_req_data_i = '0; mem_rsp_rdy_i = 1'b1;
        dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_data_i = '0;
        repeat (3) tick();
        check("rst_rdy", word_t'(mem_req_rdy_o), word_t'(0));
        check("rst_val", word_t'(mem_rsp_val_o), word_t'(0));
        check("rst_data", mem_rsp_data_o, 32'h0);
        check("rst_err", word_t'(err_o), word_t'(0));

        // Preload while still in reset: array must not depend on reset.
        dbg_write(32'h0000_0040, 32'h0000_1234);
        dbg_write(32'h0000_0000, 32'h0000_5555);
        for (int k = 0; k < 6; k++) dbg_write(32'h100 + 32'(4 * k), 32'hA0 + 32'(k));
        rst_i = 1'b0;
        tick();
        check("rdy_after_rst", word_t'(mem_req_rdy_o), word_t'(1));

        // 1: read preloaded word, latency 2.
        req(1'b0, 32'h0000_0040, 32'h0, 32'h0000_1234);
        check("lat_t1", word_t'(mem_rsp_val_o), word_t'(0));
        tick();
        check("lat_t2_val", word_t'(mem_rsp_val_o), word_t'(1));
        check("lat_t2_data", mem_rsp_data_o, 32'h0000_1234);
        check("t1_err", word_t'(err_o), word_t'(0));
        drain();

        // 2: write then back-to-back read of the same word.
        req(1'b1, 32'h0000_0080, 32'h0000_BEEF, 32'h0000_BEEF);
        req(1'b0, 32'h0000_0080, 32'h0, 32'h0000_BEEF);
        drain();

        // 3: credit limit with response backpressure.
        mem_rsp_rdy_i = 1'b0;
        n = 0;
        mem_req_val_i = 1'b1; mem_req_is_write_i = 1'b0; mem_req_addr_i = 32'h100;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (mem_req_rdy_o) begin
                exp_q.push_back(32'hA0 + 32'(n));
                n++;
            end
            tick();
            mem_req_addr_i = 32'h100 + 32'(4 * n);
        end
        check("t3_accepted", word_t'(n), word_t'(4));
        check("t3_rdy_low", word_t'(mem_req_rdy_o), word_t'(0));
        check("t3_val_held", word_t'(mem_rsp_val_o), word_t'(1));
        check("t3_data_held", mem_rsp_data_o, 32'h0000_00A0);
        mem_rsp_rdy_i = 1'b1;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (mem_req_rdy_o) begin
                exp_q.push_back(32'hA0 + 32'(n));
                n++;
            end
            tick();
            mem_req_addr_i = 32'h100 + 32'(4 * n);
            if (n == 6) mem_req_val_i = 1'b0;
        end
        mem_req_val_i = 1'b0;
        check("t3_total", word_t'(n), word_t'(6));
        drain();
        check("t3_err", word_t'(err_o), word_t'(0));

        // 4: out-of-range read and write (address aliases word 0).
        req(1'b0, 32'(DEPTH * 4), 32'h0, 32'h0);
        check("t4_err_set", word_t'(err_o), word_t'(1));
        req(1'b1, 32'(DEPTH * 4), 32'h0000_DEAD, 32'h0000_DEAD);
        req(1'b0, 32'h0000_0000, 32'h0, 32'h0000_5555);
        drain();
        check("t4_err_sticky", word_t'(err_o), word_t'(1));

        // 5: backdoor write collides with a request.
        dbg_we_i = 1'b1; dbg_addr_i = 32'h200; dbg_data_i = 32'h77;
        mem_req_val_i = 1'b1; mem_req_is_write_i = 1'b0; mem_req_addr_i = 32'h200;
        @(negedge clk);
        check("t5_rdy_stall", word_t'(mem_req_rdy_o), word_t'(0));
        tick();
        dbg_we_i = 1'b0;
        @(negedge clk);
        check("t5_rdy_next", word_t'(mem_req_rdy_o), word_t'(1));
        if (mem_req_rdy_o) exp_q.push_back(32'h77);
        tick();
        mem_req_val_i = 1'b0;
        drain();

        // 6: reset with three requests in flight drops their responses.
        mem_rsp_rdy_i = 1'b0;
        req(1'b0, 32'h104, 32'h0, 32'hA1);
        req(1'b0, 32'h108, 32'h0, 32'hA2);
        req(1'b0, 32'h10C, 32'h0, 32'hA3);
        rst_i = 1'b1;
        exp_q.delete();
        tick();
        check("t6_val_rst", word_t'(mem_rsp_val_o), word_t'(0));
        check("t6_rdy_rst", word_t'(mem_req_rdy_o), word_t'(0));
        tick();
        rst_i = 1'b0;
        mem_rsp_rdy_i = 1'b1;
        check("t6_rdy_low", word_t'(mem_req_rdy_o), word_t'(0));
        tick();
        check("t6_rdy_up", word_t'(mem_req_rdy_o), word_t'(1));
        check("t6_val_post", word_t'(mem_rsp_val_o), word_t'(0));
        check("t6_err_clr", word_t'(err_o), word_t'(0));
        req(1'b0, 32'h0000_0040, 32'h0, 32'h0000_1234);
        req(1'b0, 32'h0000_0100, 32'h0, 32'h0000_00A0);
        drain();
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_falafel_mem_responder
